// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared size codes, FSM states and byte-enable helper for the data memory
package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      RESP  = 2'd2
   } state_t;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lane;
         SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - request/response handshake bundle between load/store unit and data memory
interface data_mem_if #(
   parameter int ADDR_W = 32
);
   logic              i_req_valid;
   logic              o_req_ready;
   logic              i_req_write;
   logic [1:0]        i_req_size;
   logic              i_req_signed;
   logic [ADDR_W-1:0] i_req_addr;
   logic [31:0]       i_req_wdata;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [31:0]       o_rsp_rdata;
   logic              o_rsp_err;

   modport master (
      output i_req_valid, i_req_write, i_req_size, i_req_signed, i_req_addr, i_req_wdata,
      output i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
   );

   modport slave (
      input  i_req_valid, i_req_write, i_req_size, i_req_signed, i_req_addr, i_req_wdata,
      input  i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
   );
endinterface

// File: rtl/data_mem_lane_fmt.sv
// rtl/data_mem_lane_fmt.sv - byte-lane formatting: store replication + byte enables, or load extract + extension
module data_mem_lane_fmt
   import data_mem_pkg::*;
#(
   parameter bit LOAD = 1'b0
) (
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_lane,
   input  logic        i_signed,
   input  logic [31:0] i_data,
   output logic [3:0]  o_be,
   output logic [31:0] o_data
);

   logic [31:0] w_shift;

   always_comb begin
      o_be    = byte_en(i_size, i_lane);
      w_shift = i_data >> {i_lane, 3'b000};
      o_data  = '0;
      if (LOAD) begin
         case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
            SZ_HALF: o_data = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
            SZ_WORD: o_data = i_data;
            default: o_data = '0;
         endcase
      end else begin
         // Replicate right-aligned data into every lane; byte enables pick the live ones.
         case (i_size)
            SZ_BYTE: o_data = {4{i_data[7:0]}};
            SZ_HALF: o_data = {2{i_data[15:0]}};
            default: o_data = i_data;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-enabled single-port data memory with load extension, error checks and reset sweep
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DEPTH          = 256,
   parameter int ADDR_W         = 32,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   data_mem_if.slave   bus,
   output logic        o_init_done
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t             r_state;
   logic [IDX_W-1:0]   r_cnt;
   logic               r_init_done;
   logic               r_rsp_valid;
   logic               r_rsp_err;
   logic               r_rsp_load;
   logic [1:0]         r_ld_size;
   logic [1:0]         r_ld_lane;
   logic               r_ld_signed;
   logic [31:0]        r_rd_word;
   logic [31:0]        r_mem [DEPTH];

   logic               w_req_ready;
   logic               w_accept;
   logic [ADDR_W-3:0]  w_word;
   logic [IDX_W-1:0]   w_idx;
   logic [1:0]         w_lane;
   logic               w_range_err;
   logic               w_err;
   logic [3:0]         w_st_be;
   logic [31:0]        w_st_data;
   logic [3:0]         w_we;
   logic [IDX_W-1:0]   w_widx;
   logic [31:0]        w_wdata;
   logic [3:0]         w_ld_be_unused;
   logic [31:0]        w_ld_data;

   assign w_req_ready = (r_state == IDLE) | ((r_state == RESP) & bus.i_rsp_ready);
   assign w_accept    = bus.i_req_valid & w_req_ready;
   assign w_word      = bus.i_req_addr[ADDR_W-1:2];
   assign w_idx       = w_word[IDX_W-1:0];
   assign w_lane      = bus.i_req_addr[1:0];
   assign w_range_err = |(w_word >> IDX_W);

   assign w_err = (bus.i_req_size == SZ_BAD)
                | ((bus.i_req_size == SZ_HALF) & w_lane[0])
                | ((bus.i_req_size == SZ_WORD) & (|w_lane))
                | w_range_err;

   data_mem_lane_fmt #(.LOAD(1'b0)) u_st_fmt (
      .i_size   (bus.i_req_size),
      .i_lane   (w_lane),
      .i_signed (bus.i_req_signed),
      .i_data   (bus.i_req_wdata),
      .o_be     (w_st_be),
      .o_data   (w_st_data)
   );

   // The sweep owns the write port while in CLEAR; requests cannot be accepted then.
   always_comb begin
      w_we    = 4'b0000;
      w_widx  = w_idx;
      w_wdata = w_st_data;
      if (r_state == CLEAR) begin
         w_we    = 4'b1111;
         w_widx  = r_cnt;
         w_wdata = '0;
      end else if (w_accept & bus.i_req_write & ~w_err) begin
         w_we    = w_st_be;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int b = 0; b < 4; b++) begin
         if (w_we[b]) begin
            r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
      if (w_accept & ~bus.i_req_write & ~w_err) begin
         r_rd_word <= r_mem[w_idx];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         r_cnt       <= '0;
         r_init_done <= (CLEAR_ON_RESET == 0);
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_load  <= 1'b0;
         r_ld_size   <= SZ_WORD;
         r_ld_lane   <= 2'b00;
         r_ld_signed <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == IDX_W'(DEPTH - 1)) begin
                  r_state     <= IDLE;
                  r_init_done <= 1'b1;
               end
            end
            default: begin
               if (w_accept) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  r_rsp_load  <= ~bus.i_req_write & ~w_err;
                  r_ld_size   <= bus.i_req_size;
                  r_ld_lane   <= w_lane;
                  r_ld_signed <= bus.i_req_signed;
               end else if ((r_state == RESP) && bus.i_rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_load  <= 1'b0;
               end
            end
         endcase
      end
   end

   data_mem_lane_fmt #(.LOAD(1'b1)) u_ld_fmt (
      .i_size   (r_ld_size),
      .i_lane   (r_ld_lane),
      .i_signed (r_ld_signed),
      .i_data   (r_rd_word),
      .o_be     (w_ld_be_unused),
      .o_data   (w_ld_data)
   );

   assign bus.o_req_ready = w_req_ready;
   assign bus.o_rsp_valid = r_rsp_valid;
   assign bus.o_rsp_err   = r_rsp_err;
   assign bus.o_rsp_rdata = r_rsp_load ? w_ld_data : 32'h0;
   assign o_init_done     = r_init_done;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl
module tb_data_mem_ctrl;
   import data_mem_pkg::*;

   localparam int DEPTH = 256;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_done;
   exp_t sb[$];
   int   rsp_cyc[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_if #(.ADDR_W(32)) bus_if ();

   data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .bus         (bus_if),
      .o_init_done (init_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && bus_if.o_rsp_valid && bus_if.i_rsp_ready) begin
         if (sb.size() == 0) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("rsp_rdata", bus_if.o_rsp_rdata, e.rdata);
            check("rsp_err", {31'b0, bus_if.o_rsp_err}, {31'b0, e.err});
            rsp_cyc.push_back(cyc);
         end
      end
   end

   task automatic send(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
      int n = 0;
      bus_if.i_req_valid  = 1'b1;
      bus_if.i_req_write  = wr;
      bus_if.i_req_size   = sz;
      bus_if.i_req_signed = sg;
      bus_if.i_req_addr   = addr;
      bus_if.i_req_wdata  = wd;
      sb.push_back({exp_rd, exp_err});
      forever begin
         @(negedge clk);
         if (bus_if.o_req_ready) break;
         n++;
         if (n > 500) begin
            check("accept_timeout", 32'(n), 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus_if.i_req_valid = 1'b0;
   endtask

   task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                     input logic [31:0] exp_rd, input logic exp_err = 1'b0);
      send(1'b0, sz, sg, addr, 32'h0, exp_rd, exp_err);
   endtask

   task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                     input logic exp_err = 1'b0);
      send(1'b1, sz, 1'b0, addr, wd, 32'h0, exp_err);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic measure_clear(output int c);
      c = 0;
      do begin
         @(posedge clk);
         #1;
         c++;
      end while (!bus_if.o_req_ready && c < 1000);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int c;
      bus_if.i_req_valid  = 1'b0;
      bus_if.i_req_write  = 1'b0;
      bus_if.i_req_size   = SZ_WORD;
      bus_if.i_req_signed = 1'b0;
      bus_if.i_req_addr   = '0;
      bus_if.i_req_wdata  = '0;
      bus_if.i_rsp_ready  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'b0, bus_if.o_req_ready}, 32'd0);
      check("rst_rsp_valid", {31'b0, bus_if.o_rsp_valid}, 32'd0);
      check("rst_rsp_rdata", bus_if.o_rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'b0, bus_if.o_rsp_err}, 32'd0);
      check("rst_init_done", {31'b0, init_done}, 32'd0);

      rst_n = 1'b1;
      measure_clear(c);
      check("clear_cycles", 32'(c), 32'(DEPTH));
      check("init_done", {31'b0, init_done}, 32'd1);

      bus_if.i_rsp_ready = 1'b1;
      ld(SZ_WORD, 1'b0, 32'h0, 32'h0);
      ld(SZ_WORD, 1'b0, 32'h3FC, 32'h0);

      st(SZ_WORD, 32'h8, 32'h8081_82F3);
      ld(SZ_BYTE, 1'b1, 32'hB, 32'hFFFF_FF80);
      ld(SZ_BYTE, 1'b0, 32'h8, 32'h0000_00F3);
      ld(SZ_HALF, 1'b1, 32'hA, 32'hFFFF_8081);
      ld(SZ_HALF, 1'b0, 32'h8, 32'h0000_82F3);
      ld(SZ_BYTE, 1'b1, 32'h9, 32'hFFFF_FF82);
      ld(SZ_HALF, 1'b0, 32'hA, 32'h0000_8081);

      st(SZ_WORD, 32'h10, 32'h1122_3344);
      st(SZ_BYTE, 32'h11, 32'h1234_56AA);
      st(SZ_HALF, 32'h12, 32'h5555_BEEF);
      ld(SZ_WORD, 1'b0, 32'h10, 32'hBEEF_AA44);

      ld(SZ_HALF, 1'b1, 32'h1, 32'h0, 1'b1);
      ld(SZ_WORD, 1'b0, 32'h6, 32'h0, 1'b1);
      ld(SZ_BAD, 1'b1, 32'h10, 32'h0, 1'b1);
      ld(SZ_WORD, 1'b0, 32'h400, 32'h0, 1'b1);
      st(SZ_BAD, 32'h10, 32'hFFFF_FFFF, 1'b1);
      st(SZ_WORD, 32'h12, 32'hDEAD_DEAD, 1'b1);
      st(SZ_WORD, 32'h410, 32'hCAFE_F00D, 1'b1);
      st(SZ_BYTE, 32'h1000_0010, 32'h0000_0077, 1'b1);
      ld(SZ_WORD, 1'b0, 32'h10, 32'hBEEF_AA44);
      drain();

      bus_if.i_rsp_ready = 1'b0;
      ld(SZ_WORD, 1'b0, 32'h8, 32'h8081_82F3);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {31'b0, bus_if.o_rsp_valid}, 32'd1);
         check("hold_rdata", bus_if.o_rsp_rdata, 32'h8081_82F3);
         check("hold_req_ready", {31'b0, bus_if.o_req_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      bus_if.i_rsp_ready = 1'b1;
      drain();

      for (int i = 0; i < 8; i++) st(SZ_WORD, 32'h40 + 32'(4 * i), 32'hC0DE_0000 | 32'(i * 32'h0101));
      drain();
      rsp_cyc.delete();
      for (int i = 0; i < 8; i++) ld(SZ_WORD, 1'b0, 32'h40 + 32'(4 * i), 32'hC0DE_0000 | 32'(i * 32'h0101));
      drain();
      check("stream_count", 32'(rsp_cyc.size()), 32'd8);
      for (int i = 1; i < rsp_cyc.size(); i++) check("stream_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd1);

      bus_if.i_rsp_ready = 1'b0;
      ld(SZ_WORD, 1'b0, 32'h40, 32'hC0DE_0000);
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      check("rst_pend_valid", {31'b0, bus_if.o_rsp_valid}, 32'd0);
      check("rst_pend_ready", {31'b0, bus_if.o_req_ready}, 32'd0);
      check("rst_pend_rdata", bus_if.o_rsp_rdata, 32'd0);
      check("rst_pend_init", {31'b0, init_done}, 32'd0);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("midclear_ready", {31'b0, bus_if.o_req_ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midclear_init", {31'b0, init_done}, 32'd0);
      rst_n = 1'b1;
      measure_clear(c);
      check("reclear_cycles", 32'(c), 32'(DEPTH));

      bus_if.i_rsp_ready = 1'b1;
      ld(SZ_WORD, 1'b0, 32'h40, 32'h0);
      ld(SZ_WORD, 1'b0, 32'h10, 32'h0);
      ld(SZ_WORD, 1'b0, 32'h8, 32'h0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
